// File: rtl/relu_stream_ctrl.sv
// Job sequencer for the ReLU vector stage: source-read address generation,
// read/ReLU latency tag pipeline, lane masking, pause and completion.
`timescale 1ns/1ps
module relu_stream_ctrl #(
  parameter int unsigned BUS_NUM          = 16,
  parameter int unsigned FIXED_DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH       = 10,
  parameter int unsigned LEN_WIDTH        = 11
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  start,
  input  logic [ADDR_WIDTH-1:0]                 cfg_src_base,
  input  logic [ADDR_WIDTH-1:0]                 cfg_dst_base,
  input  logic [LEN_WIDTH-1:0]                  cfg_len,
  input  logic [BUS_NUM-1:0]                    cfg_lane_mask,
  input  logic                                  pause,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  src_ren,
  output logic [ADDR_WIDTH-1:0]                 src_raddr,
  input  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]   src_rdata,
  output logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]   relu_in_data,
  output logic [BUS_NUM-1:0]                    relu_in_vld,
  input  logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]   relu_out_data,
  input  logic [BUS_NUM-1:0]                    relu_out_vld,
  output logic                                  dst_wen,
  output logic [ADDR_WIDTH-1:0]                 dst_waddr,
  output logic [BUS_NUM*FIXED_DATA_WIDTH-1:0]   dst_wdata,
  output logic [BUS_NUM-1:0]                    dst_wmask
);

  localparam int unsigned DATA_W = BUS_NUM * FIXED_DATA_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_rptr;
  logic [ADDR_WIDTH-1:0] r_wptr;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_icnt;
  logic [LEN_WIDTH-1:0]  r_wcnt;
  logic [BUS_NUM-1:0]    r_mask;
  logic                  r_s1_vld;
  logic                  r_s2_vld;
  logic [DATA_W-1:0]     r_hold;

  logic w_launch;
  logic w_issue;
  logic w_write;
  logic w_last_issue;
  logic w_last_write;

  assign w_launch     = (r_state == S_IDLE) && start;
  assign w_issue      = (r_state == S_RUN) && !pause && (r_icnt != r_len);
  assign w_write      = r_s2_vld;
  assign w_last_issue = w_issue && ((r_icnt + LEN_WIDTH'(1)) == r_len);
  assign w_last_write = w_write && ((r_wcnt + LEN_WIDTH'(1)) == r_len);

  // Control FSM with registered busy/done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (cfg_len == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (w_last_issue) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_last_write) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Job descriptor, pointers and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len  <= '0;
      r_mask <= '0;
      r_rptr <= '0;
      r_wptr <= '0;
      r_icnt <= '0;
      r_wcnt <= '0;
    end else if (w_launch) begin
      r_len  <= cfg_len;
      r_mask <= cfg_lane_mask;
      r_rptr <= cfg_src_base;
      r_wptr <= cfg_dst_base;
      r_icnt <= '0;
      r_wcnt <= '0;
    end else begin
      if (w_issue) begin
        r_rptr <= r_rptr + ADDR_WIDTH'(1);
        r_icnt <= r_icnt + LEN_WIDTH'(1);
      end
      if (w_write) begin
        r_wptr <= r_wptr + ADDR_WIDTH'(1);
        r_wcnt <= r_wcnt + LEN_WIDTH'(1);
      end
    end
  end

  // Tag pipeline tracking SRAM read latency then ReLU latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
      r_s2_vld <= 1'b0;
      r_hold   <= '0;
    end else begin
      r_s1_vld <= w_issue;
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_hold <= src_rdata;
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign src_ren      = w_issue;
  assign src_raddr    = r_rptr;
  // Read data arrives one cycle after src_ren; hold it across idle cycles
  assign relu_in_data = r_s1_vld ? src_rdata : r_hold;
  assign relu_in_vld  = r_s1_vld ? r_mask : '0;
  assign dst_wen      = w_write;
  assign dst_waddr    = r_wptr;
  assign dst_wdata    = w_write ? relu_out_data : '0;
  assign dst_wmask    = w_write ? relu_out_vld : '0;

endmodule

// File: tb/tb_relu_stream_ctrl.sv
// Scoreboard bench for relu_stream_ctrl with SRAM and ReLU-stage models.
`timescale 1ns/1ps
module tb_relu_stream_ctrl;

  localparam int unsigned BN    = 16;
  localparam int unsigned FW    = 8;
  localparam int unsigned AW    = 10;
  localparam int unsigned LW    = 11;
  localparam int unsigned DW    = BN * FW;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_src_base = '0;
  logic [AW-1:0] cfg_dst_base = '0;
  logic [LW-1:0] cfg_len = '0;
  logic [BN-1:0] cfg_lane_mask = '0;
  logic          pause = 1'b0;
  logic          busy, done, src_ren, dst_wen;
  logic [AW-1:0] src_raddr, dst_waddr;
  logic [DW-1:0] src_rdata = '0;
  logic [DW-1:0] relu_in_data, relu_out_data, dst_wdata;
  logic [BN-1:0] relu_in_vld, relu_out_vld, dst_wmask;

  always #5 clk = ~clk;

  relu_stream_ctrl #(.BUS_NUM(BN), .FIXED_DATA_WIDTH(FW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
    .cfg_len(cfg_len), .cfg_lane_mask(cfg_lane_mask), .pause(pause),
    .busy(busy), .done(done), .src_ren(src_ren), .src_raddr(src_raddr),
    .src_rdata(src_rdata), .relu_in_data(relu_in_data), .relu_in_vld(relu_in_vld),
    .relu_out_data(relu_out_data), .relu_out_vld(relu_out_vld),
    .dst_wen(dst_wen), .dst_waddr(dst_waddr), .dst_wdata(dst_wdata), .dst_wmask(dst_wmask)
  );

  // Shared buffer: 1-cycle read, lane-masked write
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (src_ren) src_rdata <= mem[src_raddr];
    if (dst_wen)
      for (int l = 0; l < BN; l++)
        if (dst_wmask[l]) mem[dst_waddr][l*FW +: FW] <= dst_wdata[l*FW +: FW];
  end

  // ReLU stage model with one registered cycle of latency
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      relu_out_data <= '0;
      relu_out_vld  <= '0;
    end else begin
      relu_out_vld <= relu_in_vld;
      for (int l = 0; l < BN; l++)
        relu_out_data[l*FW +: FW] <= (relu_in_vld[l] && !relu_in_data[l*FW + FW - 1]) ?
                                     relu_in_data[l*FW +: FW] : '0;
    end
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BN-1:0] mask;
  } wr_t;

  wr_t           wr_q[$];
  logic [AW-1:0] rd_q[$];
  int            rd_cyc_q[$];
  int            n_checks = 0;
  int            n_fail = 0;
  int            cyc = 0;
  bit            mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  function automatic logic [DW-1:0] ref_relu(input logic [DW-1:0] v, input logic [BN-1:0] m);
    logic [DW-1:0] r;
    logic signed [FW-1:0] b;
    r = '0;
    for (int l = 0; l < BN; l++) begin
      b = v[l*FW +: FW];
      if (m[l] && b > 0) r[l*FW +: FW] = b;
    end
    return r;
  endfunction

  // Monitor: pops expected reads/writes whenever the DUT presents one
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (src_ren) begin
        if (rd_q.size() == 0) fail_now("unexpected_read");
        else check("raddr", src_raddr, rd_q.pop_front());
        rd_cyc_q.push_back(cyc);
      end
      if (dst_wen) begin
        wr_t e;
        if (wr_q.size() == 0) fail_now("unexpected_write");
        else begin
          e = wr_q.pop_front();
          check("waddr", dst_waddr, e.addr);
          check("wdata", dst_wdata, e.data);
          check("wmask", dst_wmask, e.mask);
        end
        if (rd_cyc_q.size() == 0) fail_now("write_without_read");
        else check("write_latency", cyc - rd_cyc_q.pop_front(), 2);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_src_ren"}, src_ren, 0);
    check({tag, "_src_raddr"}, src_raddr, 0);
    check({tag, "_relu_in_data"}, relu_in_data, 0);
    check({tag, "_relu_in_vld"}, relu_in_vld, 0);
    check({tag, "_dst_wen"}, dst_wen, 0);
    check({tag, "_dst_waddr"}, dst_waddr, 0);
    check({tag, "_dst_wdata"}, dst_wdata, 0);
    check({tag, "_dst_wmask"}, dst_wmask, 0);
  endtask

  // Launch one job, push its expected traffic, and time busy/done against it
  task automatic run_job(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int len,
                         input logic [BN-1:0] mask, input int pause_at, input int pause_len,
                         input bit stray_start);
    int s, done_exp, c;
    bit seen_done;
    @(posedge clk); #1;
    cfg_src_base = src; cfg_dst_base = dst; cfg_len = LW'(len); cfg_lane_mask = mask;
    start = 1'b1;
    s = cyc;
    for (int i = 0; i < len; i++) begin
      rd_q.push_back(AW'(src + i));
      wr_q.push_back('{addr: AW'(dst + i), data: ref_relu(mem[AW'(src + i)], mask), mask: mask});
    end
    if (len == 0) done_exp = s + 1;
    else done_exp = s + len + 3 + ((pause_at < len) ? pause_len : 0);
    @(negedge clk);
    check("done_cleared_at_start", done, 0);
    seen_done = 1'b0;
    for (int k = 0; k < len + pause_len + 20 && !seen_done; k++) begin
      @(posedge clk); #1;
      c = cyc;
      start = stray_start && (c == s + 4);
      if (c == s + 1 || start) begin
        cfg_src_base = AW'($urandom); cfg_dst_base = AW'($urandom);
        cfg_len = LW'($urandom_range(1, 30)); cfg_lane_mask = BN'($urandom);
      end
      pause = (pause_len > 0) && (c > s + pause_at) && (c <= s + pause_at + pause_len);
      @(negedge clk);
      check("busy", busy, (len > 0 && c < done_exp) ? 1 : 0);
      if (done) begin
        seen_done = 1'b1;
        check("done_cycle", c - s, done_exp - s);
      end
    end
    start = 1'b0;
    pause = 1'b0;
    if (!seen_done) fail_now("done_timeout");
    check("reads_outstanding", rd_q.size(), 0);
    check("writes_outstanding", wr_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] orig [4];
    int s, len, sb, pa, pl;
    logic [BN-1:0] m;

    for (int a = 0; a < DEPTH; a++) mem[a] = {$urandom, $urandom, $urandom, $urandom};
    mem[0] = 128'h80_7F_00_FF_01_FE_40_C0_81_7E_10_F0_00_80_7F_55;
    mem[1] = 128'h7F_80_FF_00_FE_01_C0_40_7E_81_F0_10_80_00_55_7F;
    mem[2] = 128'h00_00_00_00_80_80_80_80_7F_7F_7F_7F_FF_FF_FF_FF;
    mem[3] = 128'h01_02_03_04_F1_F2_F3_F4_80_7F_80_7F_00_01_FF_80;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;

    // basic, zero length, pause with stray start, pause during drain
    run_job(10'd0, 10'd64, 4, '1, 99, 0, 1'b0);
    run_job(10'd5, 10'd70, 0, '1, 99, 0, 1'b0);
    run_job(10'd8, 10'd80, 8, '1, 2, 3, 1'b1);
    run_job(10'd20, 10'd120, 5, '1, 5, 2, 1'b0);

    // wrap-around in place
    for (int i = 0; i < 4; i++) orig[i] = mem[AW'(1022 + i)];
    run_job(10'd1022, 10'd1022, 4, '1, 99, 0, 1'b0);
    for (int i = 0; i < 4; i++) check("inplace_mem", mem[AW'(1022 + i)], ref_relu(orig[i], '1));

    // lane masking
    run_job(10'd100, 10'd300, 5, 16'h00F0, 99, 0, 1'b0);
    run_job(10'd200, 10'd400, 4, 16'h0000, 99, 0, 1'b0);

    // randomized disjoint jobs with random pauses
    for (int j = 0; j < 6; j++) begin
      len = $urandom_range(1, 20);
      sb  = $urandom_range(0, 399);
      pa  = $urandom_range(0, len);
      pl  = $urandom_range(0, 3);
      m   = BN'($urandom);
      run_job(AW'(sb), AW'(sb + 512), len, m, pa, pl, 1'($urandom_range(0, 1)));
    end

    // reset during the third write of a 10-vector job
    @(posedge clk); #1;
    cfg_src_base = 10'd600; cfg_dst_base = 10'd700; cfg_len = 11'd10; cfg_lane_mask = '1;
    start = 1'b1;
    s = cyc;
    for (int i = 0; i < 10; i++) begin
      rd_q.push_back(AW'(600 + i));
      wr_q.push_back('{addr: AW'(700 + i), data: ref_relu(mem[AW'(600 + i)], '1), mask: '1});
    end
    while (cyc < s + 5) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("third_write_present", dst_wen, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midjob_reset");
    wr_q.delete();
    rd_q.delete();
    rd_cyc_q.delete();
    repeat (2) begin
      @(negedge clk);
      check("no_done_in_reset", done, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_done_after_abort", done, 0);
      check("idle_after_abort", busy, 0);
    end
    run_job(10'd600, 10'd700, 2, '1, 99, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
